// File: rtl/delay_pkg.sv
// Shared constants, FSM state type and sample-format helpers
// for the delay pedal mixer.
package delay_pkg;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 8;
    localparam int PROD_W   = SAMPLE_W + 1 + GAIN_W;
    localparam int SUM_W    = SAMPLE_W + 2;

    localparam logic [SAMPLE_W-1:0] MIDSCALE =
        {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MUL_FB,
        SUM_FB,
        MUL_MIX,
        SUM_MIX,
        DONE
    } mixer_state_t;

    function automatic logic signed [SAMPLE_W-1:0] to_signed(
        input logic [SAMPLE_W-1:0] x
    );
        return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
    endfunction

    function automatic logic [SAMPLE_W-1:0] to_offset(
        input logic signed [SAMPLE_W-1:0] x
    );
        return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
    endfunction

    // In range when every bit above the sample sign bit matches it
    function automatic logic signed [SAMPLE_W-1:0] sat(
        input logic signed [SUM_W-1:0] v
    );
        logic [SUM_W-SAMPLE_W:0] top;
        top = v[SUM_W-1:SAMPLE_W-1];
        if (top == '0 || top == '1)
            return v[SAMPLE_W-1:0];
        else if (v[SUM_W-1])
            return {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/delay_mixer_seq_mult.sv
// Serial shift-add multiplier: signed (SAMPLE_W+1) x unsigned GAIN_W,
// one multiplier bit per cycle, LSB first.
module seq_mult
    import delay_pkg::*;
(
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     start,
    input  logic signed [SAMPLE_W:0] mcand,
    input  logic [GAIN_W-1:0]        mplier,
    output logic                     busy,
    output logic                     done,
    output logic signed [PROD_W-1:0] product
);

    localparam int CNT_W = $clog2(GAIN_W + 1);

    logic signed [PROD_W-1:0] addend;
    logic [GAIN_W-1:0]        bits;
    logic [CNT_W-1:0]         cnt;

    // done marks the final step; product is complete after this edge
    assign done = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            bits    <= '0;
            addend  <= '0;
            product <= '0;
        end else if (start && !busy) begin
            busy    <= 1'b1;
            cnt     <= CNT_W'(GAIN_W);
            bits    <= mplier;
            addend  <= {{GAIN_W{mcand[SAMPLE_W]}}, mcand};
            product <= '0;
        end else if (busy) begin
            if (bits[0])
                product <= product + addend;
            addend <= addend <<< 1;
            bits   <= bits >> 1;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/delay_mixer.sv
// Feedback and wet/dry mix stage of the delay pedal; one shared
// serial multiplier serves both products.
module delay_mixer
    import delay_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] dry_sample,
    input  logic [SAMPLE_W-1:0] dly_sample,
    input  logic [GAIN_W-1:0]   fb_gain,
    input  logic [GAIN_W-1:0]   mix_gain,
    input  logic                bypass,
    output logic                busy,
    output logic                done,
    output logic [SAMPLE_W-1:0] wr_sample,
    output logic [SAMPLE_W-1:0] out_sample
);

    mixer_state_t state;

    logic signed [SAMPLE_W-1:0] d_r;
    logic signed [SAMPLE_W-1:0] y_r;
    logic [GAIN_W-1:0]          mix_r;
    logic signed [SAMPLE_W-1:0] dly_s;

    logic                       m_start;
    logic                       m_busy;
    logic                       m_done;
    logic signed [SAMPLE_W:0]   m_a;
    logic [GAIN_W-1:0]          m_b;
    logic signed [PROD_W-1:0]   m_p;
    logic signed [PROD_W-1:0]   scaled;
    logic signed [SUM_W-1:0]    sum;

    assign dly_s  = to_signed(dly_sample);
    assign scaled = m_p >>> GAIN_W;

    // The first multiply is loaded straight from the ports so that
    // MUL_FB starts in the cycle right after the accepted start
    always_comb begin
        m_start = 1'b0;
        m_a     = {y_r[SAMPLE_W-1], y_r} - {d_r[SAMPLE_W-1], d_r};
        m_b     = mix_r;
        if (state == IDLE) begin
            m_a     = {dly_s[SAMPLE_W-1], dly_s};
            m_b     = fb_gain;
            m_start = start && !bypass && !m_busy;
        end else if (state == SUM_FB) begin
            m_start = 1'b1;
        end
        sum = {{2{d_r[SAMPLE_W-1]}}, d_r} + scaled[SUM_W-1:0];
    end

    seq_mult u_mult (
        .clk     (clk),
        .nrst    (nrst),
        .start   (m_start),
        .mcand   (m_a),
        .mplier  (m_b),
        .busy    (m_busy),
        .done    (m_done),
        .product (m_p)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_sample  <= MIDSCALE;
            out_sample <= MIDSCALE;
            d_r        <= '0;
            y_r        <= '0;
            mix_r      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        d_r   <= to_signed(dry_sample);
                        y_r   <= dly_s;
                        mix_r <= mix_gain;
                        busy  <= 1'b1;
                        if (bypass) begin
                            wr_sample  <= dry_sample;
                            out_sample <= dry_sample;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= MUL_FB;
                        end
                    end
                end
                MUL_FB: begin
                    if (m_done)
                        state <= SUM_FB;
                end
                SUM_FB: begin
                    wr_sample <= to_offset(sat(sum));
                    state     <= MUL_MIX;
                end
                MUL_MIX: begin
                    if (m_done)
                        state <= SUM_MIX;
                end
                SUM_MIX: begin
                    out_sample <= to_offset(sat(sum));
                    done       <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_mixer.sv
// Self-checking bench for delay_mixer: directed table, corner
// sequences and randomized ops against an arithmetic model.
module tb_delay_mixer;

    localparam int SW = 16;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          start = 1'b0;
    logic          bypass = 1'b0;
    logic [SW-1:0] dry_sample = '0;
    logic [SW-1:0] dly_sample = '0;
    logic [GW-1:0] fb_gain = '0;
    logic [GW-1:0] mix_gain = '0;
    logic          busy;
    logic          done;
    logic [SW-1:0] wr_sample;
    logic [SW-1:0] out_sample;

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit            byp;
        logic [SW-1:0] dry;
        logic [SW-1:0] dly;
        logic [GW-1:0] fb;
        logic [GW-1:0] mix;
        logic [SW-1:0] wr;
        logic [SW-1:0] out;
        int            lat;
    } vec_t;

    delay_mixer dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .dry_sample (dry_sample),
        .dly_sample (dly_sample),
        .fb_gain    (fb_gain),
        .mix_gain   (mix_gain),
        .bypass     (bypass),
        .busy       (busy),
        .done       (done),
        .wr_sample  (wr_sample),
        .out_sample (out_sample)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // floor(a*g/256) via integer division with explicit floor correction
    function automatic int fdiv(input int p);
        int q;
        q = p / 256;
        if (p < 0 && q * 256 != p) q = q - 1;
        return q;
    endfunction

    function automatic vec_t model(input bit byp, input logic [SW-1:0] dry,
                                   input logic [SW-1:0] dly,
                                   input logic [GW-1:0] fb,
                                   input logic [GW-1:0] mix);
        vec_t v;
        int d, y;
        d = int'(dry) - 32768;
        y = int'(dly) - 32768;
        v.byp = byp; v.dry = dry; v.dly = dly; v.fb = fb; v.mix = mix;
        if (byp) begin
            v.wr = dry; v.out = dry; v.lat = 1;
        end else begin
            v.wr  = SW'(clamp(d + fdiv(y * int'(fb))) + 32768);
            v.out = SW'(clamp(d + fdiv((y - d) * int'(mix))) + 32768);
            v.lat = 19;
        end
        return v;
    endfunction

    // Run one op; extra_at > 0 injects a second start with junk
    // operands in that cycle, which must be ignored
    task automatic run_op(input vec_t v, input int extra_at, input string tag);
        int ndone = 0;
        int dcyc = -1;
        bypass = v.byp; dry_sample = v.dry; dly_sample = v.dly;
        fb_gain = v.fb; mix_gain = v.mix; start = 1'b1;
        for (int c = 1; c <= v.lat + 3; c++) begin
            @(posedge clk); #1;
            start      = (c == extra_at);
            dry_sample = SW'($urandom);
            dly_sample = SW'($urandom);
            fb_gain    = GW'($urandom);
            mix_gain   = GW'($urandom);
            bypass     = 1'($urandom);
            chk({tag, " busy"}, int'(busy), int'(c <= v.lat));
            if (done) begin
                ndone++;
                dcyc = c;
                chk({tag, " wr"}, int'(wr_sample), int'(v.wr));
                chk({tag, " out"}, int'(out_sample), int'(v.out));
            end
        end
        start = 1'b0;
        chk({tag, " done count"}, ndone, 1);
        chk({tag, " done cycle"}, dcyc, v.lat);
        chk({tag, " wr hold"}, int'(wr_sample), int'(v.wr));
    endtask

    vec_t tbl[7];

    initial begin
        vec_t v;
        int ndone;

        tbl[0] = '{0, 16'h8000, 16'hC000, 8'h80, 8'h80, 16'hA000, 16'hA000, 19};
        tbl[1] = '{0, 16'hF000, 16'hF000, 8'hFF, 8'hFF, 16'hFFFF, 16'hF000, 19};
        tbl[2] = '{0, 16'h0000, 16'h0000, 8'hFF, 8'h00, 16'h0000, 16'h0000, 19};
        tbl[3] = '{1, 16'h1234, 16'hFFFF, 8'h40, 8'h40, 16'h1234, 16'h1234, 1};
        tbl[4] = '{0, 16'h8000, 16'h7FFF, 8'h01, 8'h01, 16'h7FFF, 16'h7FFF, 19};
        tbl[5] = '{0, 16'hFFFF, 16'h0000, 8'h00, 8'hFF, 16'hFFFF, 16'h00FF, 19};
        tbl[6] = '{0, 16'h4321, 16'hABCD, 8'h00, 8'h00, 16'h4321, 16'h4321, 19};

        #2 nrst = 1'b0;
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset wr", int'(wr_sample), 16'h8000);
        chk("reset out", int'(out_sample), 16'h8000);
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i])
            run_op(tbl[i], 0, $sformatf("vec%0d", i));

        run_op(tbl[0], 5, "start in busy");
        run_op(tbl[1], 19, "start in done");
        run_op(tbl[3], 1, "bypass start in done");

        for (int i = 0; i < 30; i++) begin
            v = model(($urandom_range(7) == 0), SW'($urandom), SW'($urandom),
                      GW'($urandom), GW'($urandom));
            run_op(v, (i % 3 == 0) ? int'($urandom_range(2, 18)) : 0,
                   $sformatf("rand%0d", i));
        end

        bypass = 1'b0; dry_sample = tbl[0].dry; dly_sample = tbl[0].dly;
        fb_gain = tbl[0].fb; mix_gain = tbl[0].mix; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 nrst = 1'b0;
        #1;
        chk("midreset busy", int'(busy), 0);
        chk("midreset done", int'(done), 0);
        chk("midreset wr", int'(wr_sample), 16'h8000);
        chk("midreset out", int'(out_sample), 16'h8000);
        @(negedge clk) nrst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midreset no done", ndone, 0);
        run_op(tbl[0], 0, "after reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
